// File: rtl/obstacle_scheduler_if.sv
// Obstacle scheduler bus: game controls in, per-slot obstacle state out.
// rand_val carries the rng value; "rand" is a reserved word in SystemVerilog.
interface obstacle_scheduler_if;
  logic        halt;
  logic        tick;
  logic [4:0]  rand_val;
  logic [2:0]  obst_active;
  logic [32:0] obst_x;
  logic [5:0]  obst_type;
  logic [2:0]  step;
  logic        spawn_pulse;
  logic [7:0]  spawn_count;

  modport master (
    output halt, tick, rand_val,
    input  obst_active, obst_x, obst_type,
    input  step, spawn_pulse, spawn_count
  );

  modport slave (
    input  halt, tick, rand_val,
    output obst_active, obst_x, obst_type,
    output step, spawn_pulse, spawn_count
  );
endinterface

// File: rtl/obstacle_scheduler.sv
// Three-slot cactus scheduler: spawns after a randomised gap, scrolls per tick,
// retires off-screen slots and ramps scroll speed every few spawns.
module obstacle_scheduler #(
  parameter int SPAWN_X      = 667,
  parameter int OBST_W       = 27,
  parameter int MIN_GAP      = 60,
  parameter int GAP_SCALE    = 4,
  parameter int STEP_INIT    = 2,
  parameter int STEP_MAX     = 6,
  parameter int LEVEL_SPAWNS = 8
) (
  input logic clk,
  input logic reset,
  obstacle_scheduler_if.slave bus
);

  if (SPAWN_X <= OBST_W || MIN_GAP + 7 * GAP_SCALE > 255) begin : g_bad_params
    $error("obstacle_scheduler: parameter set out of range");
  end

  typedef enum logic {RUN, FROZEN} state_t;

  state_t      state;
  logic [2:0]  active;
  logic [10:0] xs [3];
  logic [1:0]  types [3];
  logic [7:0]  gap;
  logic [7:0]  level;
  logic [7:0]  count;
  logic [2:0]  step_q;
  logic        pulse;

  logic        work;
  logic [2:0]  free;
  logic [1:0]  sel;
  logic [1:0]  new_type;
  logic [7:0]  new_gap;
  logic [10:0] step_x;

  always_comb begin
    work     = (state == RUN) && bus.tick && !bus.halt;
    free     = ~active;
    step_x   = {8'd0, step_q};
    new_type = (bus.rand_val[1:0] == 2'd3) ? 2'd0 : bus.rand_val[1:0];
    new_gap  = 8'(MIN_GAP + 32'(bus.rand_val[4:2]) * GAP_SCALE);
    sel      = 2'd0;
    priority case (1'b1)
      free[0]: sel = 2'd0;
      free[1]: sel = 2'd1;
      free[2]: sel = 2'd2;
      default: sel = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= RUN;
      active <= '0;
      for (int i = 0; i < 3; i++) begin
        xs[i]    <= '0;
        types[i] <= '0;
      end
      gap    <= 8'(MIN_GAP);
      level  <= '0;
      count  <= '0;
      step_q <= 3'(STEP_INIT);
      pulse  <= 1'b0;
    end else begin
      pulse <= 1'b0;
      unique case (state)
        RUN: begin
          if (bus.halt) state <= FROZEN;
          if (work) begin
            for (int i = 0; i < 3; i++) begin
              if (active[i]) begin
                if (xs[i] < step_x) begin
                  active[i] <= 1'b0;
                  xs[i]     <= '0;
                end else begin
                  xs[i] <= xs[i] - step_x;
                end
              end
            end
            // free mask is sampled before this tick's retires
            if (gap != 8'd0) begin
              gap <= gap - 8'd1;
            end else if (|free) begin
              active[sel] <= 1'b1;
              xs[sel]     <= 11'(SPAWN_X);
              types[sel]  <= new_type;
              gap         <= new_gap;
              pulse       <= 1'b1;
              if (count != 8'hff) count <= count + 8'd1;
              if (level == 8'(LEVEL_SPAWNS - 1)) begin
                level <= '0;
                if (step_q != 3'(STEP_MAX)) step_q <= step_q + 3'd1;
              end else begin
                level <= level + 8'd1;
              end
            end
          end
        end
        FROZEN: begin
          if (!bus.halt) state <= RUN;
        end
      endcase
    end
  end

  assign bus.obst_active = active;
  assign bus.obst_x      = {xs[2], xs[1], xs[0]};
  assign bus.obst_type   = {types[2], types[1], types[0]};
  assign bus.step        = step_q;
  assign bus.spawn_pulse = pulse;
  assign bus.spawn_count = count;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Directed bench for obstacle_scheduler: tick-indexed vector table plus
// halt, speed-ramp and mid-play reset sequences.
module tb_obstacle_scheduler;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  int   tick_n = 0;
  bit   halt_pulse = 1'b0;

  obstacle_scheduler_if ifc ();

  obstacle_scheduler dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  always #20 clk = ~clk;

  typedef struct {
    int       t;
    bit [4:0] r;
    int       slot;
    int       act;
    int       x;
    int       typ;
    int       pulse;
    int       cnt;
    int       stp;
  } vec_t;

  vec_t vecs [10];

  always @(negedge clk)
    if (ifc.halt && ifc.spawn_pulse) halt_pulse = 1'b1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic do_tick(input bit [4:0] r);
    @(negedge clk);
    ifc.rand_val = r;
    ifc.tick = 1'b1;
    @(negedge clk);
    ifc.tick = 1'b0;
  endtask

  function automatic int xs(input int s);
    logic [32:0] v;
    v = ifc.obst_x;
    return int'(v[11*s +: 11]);
  endfunction

  function automatic int ty(input int s);
    logic [5:0] v;
    v = ifc.obst_type;
    return int'(v[2*s +: 2]);
  endfunction

  initial begin
    #5ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{60,  5'd3,  0, 0, 0,   0, 0, 0, 2};
    vecs[1] = '{61,  5'd3,  0, 1, 667, 0, 1, 1, 2};
    vecs[2] = '{62,  5'd3,  0, 1, 665, 0, 0, 1, 2};
    vecs[3] = '{122, 5'd30, 1, 3, 667, 2, 1, 2, 2};
    vecs[4] = '{123, 5'd3,  0, 3, 543, 0, 0, 2, 2};
    vecs[5] = '{211, 5'd1,  2, 7, 667, 1, 1, 3, 2};
    vecs[6] = '{300, 5'd3,  1, 7, 311, 2, 0, 3, 2};
    vecs[7] = '{394, 5'd3,  0, 7, 1,   0, 0, 3, 2};
    vecs[8] = '{395, 5'd3,  0, 6, 0,   0, 0, 3, 2};
    vecs[9] = '{396, 5'd3,  0, 7, 667, 0, 1, 4, 2};

    reset = 1'b1;
    ifc.halt = 1'b0;
    ifc.tick = 1'b0;
    ifc.rand_val = 5'd3;
    repeat (3) @(negedge clk);
    chk("rst_active", int'(ifc.obst_active), 0);
    chk("rst_x", int'(ifc.obst_x), 0);
    chk("rst_step", int'(ifc.step), 2);
    chk("rst_count", int'(ifc.spawn_count), 0);
    chk("rst_pulse", int'(ifc.spawn_pulse), 0);
    reset = 1'b0;

    foreach (vecs[k]) begin
      while (tick_n < vecs[k].t) begin
        tick_n++;
        do_tick((tick_n == vecs[k].t) ? vecs[k].r : 5'd3);
      end
      chk($sformatf("v%0d_active", k), int'(ifc.obst_active), vecs[k].act);
      chk($sformatf("v%0d_x", k), xs(vecs[k].slot), vecs[k].x);
      chk($sformatf("v%0d_type", k), ty(vecs[k].slot), vecs[k].typ);
      chk($sformatf("v%0d_pulse", k), int'(ifc.spawn_pulse), vecs[k].pulse);
      chk($sformatf("v%0d_count", k), int'(ifc.spawn_count), vecs[k].cnt);
      chk($sformatf("v%0d_step", k), int'(ifc.step), vecs[k].stp);
    end

    // freeze with three live slots
    @(negedge clk);
    ifc.halt = 1'b1;
    repeat (100) do_tick(5'd3);
    chk("halt_active", int'(ifc.obst_active), 7);
    chk("halt_x0", xs(0), 667);
    chk("halt_x1", xs(1), 119);
    chk("halt_x2", xs(2), 297);
    chk("halt_type", int'(ifc.obst_type), 6'h18);
    chk("halt_count", int'(ifc.spawn_count), 4);
    chk("halt_nopulse", int'(halt_pulse), 0);
    ifc.halt = 1'b0;
    repeat (2) @(negedge clk);
    do_tick(5'd3);
    chk("resume_x0", xs(0), 665);
    chk("resume_x1", xs(1), 117);
    chk("resume_x2", xs(2), 295);
    chk("resume_pulse", int'(ifc.spawn_pulse), 0);

    // speed ramp: one step per 8 spawns, capped at 6
    for (int t = 0; t < 8000 && ifc.spawn_count < 8'd40; t++) begin
      do_tick(5'd3);
      if (ifc.spawn_pulse) begin
        int c;
        int e;
        c = int'(ifc.spawn_count);
        e = 2 + c / 8;
        if (e > 6) e = 6;
        chk($sformatf("ramp_step_c%0d", c), int'(ifc.step), e);
      end
    end
    chk("ramp_reached40", int'(ifc.spawn_count), 40);
    chk("ramp_live", int'(ifc.obst_active != 3'd0), 1);

    // reset while slots are live
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_active", int'(ifc.obst_active), 0);
    chk("mid_rst_x", int'(ifc.obst_x), 0);
    chk("mid_rst_step", int'(ifc.step), 2);
    chk("mid_rst_count", int'(ifc.spawn_count), 0);
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
